// File: rtl/stopwatch_display_mux.sv
// stopwatch_display_mux
//   Scans a 4-digit common-anode seven-segment display from the stopwatch's
//   16-bit BCD time word {min-tens, min-units, sec-tens, sec-units}.
//   Each digit owns a slot of SCAN_DIV clocks. The first BLANK_CYCLES of a
//   slot keep every anode off so the previous digit cannot ghost into the
//   next one. The time word is captured once per frame (at the 3->0 digit
//   wrap) so a frame never mixes two different times. The minutes-tens digit
//   is blanked when zero. The colon (DP on digit 2) is steady while stopped
//   and blinks every BLINK_FRAMES frames while running.
//
// Ports
//   clk      in   1   system clock
//   RESET    in   1   asynchronous, active-high reset
//   BCD      in  16   [4:1]=sec units, [8:5]=sec tens, [12:9]=min units,
//                     [16:13]=min tens
//   RUNNING  in   1   stopwatch is counting (blinks the colon)
//   SEG      out  7   active-low segments, SEG[1]=a ... SEG[7]=g
//   DP       out  1   active-low decimal point / colon
//   AN       out  4   active-low anodes, AN[1] = rightmost digit
module stopwatch_display_mux #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [16:1] BCD,
  input  logic        RUNNING,
  output logic [7:1]  SEG,
  output logic        DP,
  output logic [4:1]  AN
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  // Active-low gfedcba pattern; anything that is not a decimal digit shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b0111111;
    endcase
    return pattern;
  endfunction

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [16:1]   snap_q, snap_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;
  logic [7:1]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [4:1]    an_q, an_d;

  logic [3:0]    digit_s;
  logic [4:1]    an_sel_s;
  logic          blank_s;

  // Scan state: prescaler, digit index, per-frame snapshot and blink phase.
  always_comb begin
    pre_d   = pre_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    frame_d = frame_q;
    blink_d = blink_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
      // The 3->0 wrap is the frame boundary: capture the time word and
      // advance the blink frame counter.
      if (idx_q == 2'd3) begin
        snap_d = BCD;
        if (frame_q == FRAME_LAST) begin
          frame_d = '0;
          blink_d = ~blink_q;
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end else begin
        snap_d = snap_q;
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Output values for the current prescaler/index state, registered below.
  always_comb begin
    digit_s  = 4'd0;
    an_sel_s = 4'b1111;
    case (idx_q)
      2'd0: begin digit_s = snap_q[4:1];   an_sel_s = 4'b1110; end
      2'd1: begin digit_s = snap_q[8:5];   an_sel_s = 4'b1101; end
      2'd2: begin digit_s = snap_q[12:9];  an_sel_s = 4'b1011; end
      2'd3: begin digit_s = snap_q[16:13]; an_sel_s = 4'b0111; end
      default: begin digit_s = 4'd0; an_sel_s = 4'b1111; end
    endcase

    blank_s = (pre_q < BLANK_LIM);

    if (blank_s) begin
      an_d = 4'b1111;
    end else begin
      an_d = an_sel_s;
    end

    // Leading minutes-tens zero is dark but its anode still runs, keeping
    // every slot the same length and brightness budget.
    if ((idx_q == 2'd3) && (digit_s == 4'd0)) begin
      seg_d = 7'b1111111;
    end else begin
      seg_d = seg_decode(digit_s);
    end

    if (!blank_s && (idx_q == 2'd2) && (!RUNNING || blink_q)) begin
      dp_d = 1'b0;
    end else begin
      dp_d = 1'b1;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      pre_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'h0000;
      frame_q <= '0;
      blink_q <= 1'b0;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      an_q    <= 4'b1111;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign SEG = seg_q;
  assign DP  = dp_q;
  assign AN  = an_q;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Testbench for stopwatch_display_mux (SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2).
// Fixed-pattern frames are checked from a constant table; every cycle is also
// checked against a cycle-count based reference model.
module tb_stopwatch_display_mux;

  localparam int SD    = 4;
  localparam int BL    = 1;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SD;
  localparam int DEPTH = 4096;

  logic        clk;
  logic        rst;
  logic [15:0] bcd;
  logic        running;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  stopwatch_display_mux #(
    .SCAN_DIV(SD),
    .BLANK_CYCLES(BL),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .RESET(rst),
    .BCD(bcd),
    .RUNNING(running),
    .SEG(seg),
    .DP(dp),
    .AN(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0][6:0] segs;   // segs[i] = expected SEG on digit index i
  } vec_t;

  vec_t        tbl [7];
  logic [6:0]  dec_tbl [16];
  logic [3:0]  an_tbl [4];
  logic [15:0] bcd_at [DEPTH];
  logic        run_at [DEPTH];
  int          n;
  int          tests;
  int          fails;
  int          dp_low [4];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (edge %0d): got %h expected %h", nm, n, act, exp);
    end
  endtask

  // Reference: position in the scan follows purely from the edge count since reset.
  task automatic model_check();
    int s, p, i, f;
    logic [15:0] snap;
    logic [3:0]  d;
    logic [3:0]  ean;
    logic [6:0]  eseg;
    logic        edp;
    logic        ph;
    s = n - 1;
    p = s % SD;
    i = (s / SD) % 4;
    f = s / FRAME;
    if (f == 0) snap = 16'h0000;
    else        snap = bcd_at[FRAME * f];
    d    = snap[4*i +: 4];
    ean  = (p < BL) ? 4'hF : ~(4'b0001 << i);
    eseg = (i == 3 && d == 4'h0) ? 7'h7F : dec_tbl[d];
    ph   = ((f / BF) % 2) == 1;
    edp  = (p >= BL && i == 2 && (!run_at[n] || ph)) ? 1'b0 : 1'b1;
    chk("model_an", 16'(an), 16'(ean));
    if (p >= BL) chk("model_seg", 16'(seg), 16'(eseg));
    chk("model_dp", 16'(dp), 16'(edp));
  endtask

  task automatic do_cycle();
    if (n + 1 < DEPTH) begin
      bcd_at[n+1] = bcd;
      run_at[n+1] = running;
    end else begin
      $display("FAIL model_depth: got %0d expected below %0d", n + 1, DEPTH);
      fails++;
    end
    @(posedge clk);
    n++;
    @(negedge clk);
    model_check();
  endtask

  // One cycle, then compare against table entry e (RUNNING held low).
  task automatic step_e(input int e);
    int s, p, i;
    do_cycle();
    s = n - 1;
    p = s % SD;
    i = (s / SD) % 4;
    chk("tbl_an", 16'(an), (p < BL) ? 16'h000F : 16'(an_tbl[i]));
    if (p >= BL) chk("tbl_seg", 16'(seg), 16'(tbl[e].segs[i]));
    chk("tbl_dp", 16'(dp), (p >= BL && i == 2) ? 16'h0000 : 16'h0001);
  endtask

  // Run until the edge that snapshots the current BCD, checking entry e.
  task automatic to_boundary(input int e);
    for (int k = 0; k < FRAME; k++) begin
      if (e >= 0) step_e(e);
      else        do_cycle();
      if (n % FRAME == 0) break;
    end
  endtask

  initial begin
    tests = 0; fails = 0; n = 0;
    dec_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    an_tbl  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    tbl[0] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    tbl[1] = '{16'h4059, {7'b0011001, 7'b1000000, 7'b0010010, 7'b0010000}};
    tbl[2] = '{16'h0A07, {7'b1111111, 7'b0111111, 7'b1000000, 7'b1111000}};
    tbl[3] = '{16'h4959, {7'b0011001, 7'b0010000, 7'b0010010, 7'b0010000}};
    tbl[4] = '{16'h0100, {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000}};
    tbl[5] = '{16'hF86E, {7'b0111111, 7'b0000000, 7'b0000010, 7'b0111111}};
    tbl[6] = '{16'h0000, {7'b1111111, 7'b1000000, 7'b1000000, 7'b1000000}};

    rst = 1'b1; running = 1'b0; bcd = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_an", 16'(an), 16'h000F);
    chk("reset_seg", 16'(seg), 16'h007F);
    chk("reset_dp", 16'(dp), 16'h0001);
    rst = 1'b0; n = 0;

    // First frame shows the zero snapshot, second shows 1234.
    for (int k = 0; k < FRAME; k++) step_e(6);
    for (int k = 0; k < FRAME; k++) step_e(0);

    for (int e = 0; e < 6; e++) begin
      bcd = tbl[e].bcd;
      to_boundary(-1);
      for (int k = 0; k < FRAME; k++) step_e(e);
    end

    // BCD change during index 1 waits for the next frame boundary.
    bcd = 16'h1234;
    to_boundary(-1);
    for (int k = 0; k < FRAME + 5; k++) step_e(0);
    bcd = 16'h4059;
    to_boundary(0);
    for (int k = 0; k < FRAME; k++) step_e(1);

    // Asynchronous reset inside the index-2 slot.
    for (int k = 0; k < FRAME; k++) begin
      if (n % FRAME == 9) break;
      do_cycle();
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an", 16'(an), 16'h000F);
    chk("async_rst_seg", 16'(seg), 16'h007F);
    chk("async_rst_dp", 16'(dp), 16'h0001);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; n = 0;

    // Blink while running: frames 0,1 dark colon, frames 2,3 lit.
    running = 1'b1; bcd = 16'h4959;
    for (int f = 0; f < 4; f++) dp_low[f] = 0;
    for (int c = 0; c < 4 * FRAME; c++) begin
      do_cycle();
      if (c == 0) chk("post_rst_first_an", 16'(an), 16'h000F);
      if (c == 1) chk("post_rst_second_an", 16'(an), 16'h000E);
      if (dp == 1'b0) dp_low[(n - 1) / FRAME]++;
    end
    chk("blink_f0", 16'(dp_low[0]), 16'd0);
    chk("blink_f1", 16'(dp_low[1]), 16'd0);
    chk("blink_f2", 16'(dp_low[2]), 16'd3);
    chk("blink_f3", 16'(dp_low[3]), 16'd3);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 40 * FRAME; c++) begin
      if ($urandom_range(0, 7) == 0) bcd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) running = ~running;
      do_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
